// File: rtl/rdoq_pkg.sv
// Shared widths for the RDOQ distortion datapath.
// Derived widths follow from the unsigned level being widened by one sign bit before the subtract.
package rdoq_pkg;

    localparam int LEVEL_WIDTH     = 64;
    localparam int ABS_LEVEL_WIDTH = 32;
    localparam int QBITS_WIDTH     = 6;
    localparam int SCALE_WIDTH     = 32;
    localparam int OUT_WIDTH       = 162;

    localparam int DIFF_W  = LEVEL_WIDTH + 1;
    localparam int SQ_W    = 2 * DIFF_W;
    localparam int SHIFT_W = LEVEL_WIDTH + ABS_LEVEL_WIDTH;

    // Number of register stages between data_valid_in and data_valid_out.
    localparam int PIPE_DEPTH = 3;

endpackage

// File: rtl/rdoq_recon_clamp.sv
// Reconstructs a level as ui_abs_level << i_q_bits and saturates it to the level width.
// Purely combinational; the caller registers the result.
module rdoq_recon_clamp
    import rdoq_pkg::*;
#(
    parameter int LW = LEVEL_WIDTH,
    parameter int AW = ABS_LEVEL_WIDTH,
    parameter int QW = QBITS_WIDTH
) (
    input  logic [AW-1:0] ui_abs_level,
    input  logic [QW-1:0] i_q_bits,
    output logic [LW-1:0] recon
);

    localparam int SW = LW + AW;

    logic [SW-1:0] shifted;
    logic          overflow;

    // Widen before shifting so no significant bit is lost at any shift amount.
    assign shifted  = SW'(ui_abs_level) << i_q_bits;
    assign overflow = |shifted[SW-1:LW];

    always_comb begin
        recon = shifted[LW-1:0];
        if (overflow) begin
            recon = '1;
        end
    end

endmodule

// File: rtl/rdoq_dist_cal.sv
// RDOQ distortion: (level - clamp(abs << q))^2 * error_scale, three register stages.
// Streaming valid only: a sample is taken on every edge where data_valid_in is 1 (no ready).
module rdoq_dist_cal
    import rdoq_pkg::*;
#(
    parameter int LEVEL_WIDTH     = rdoq_pkg::LEVEL_WIDTH,
    parameter int ABS_LEVEL_WIDTH = rdoq_pkg::ABS_LEVEL_WIDTH,
    parameter int QBITS_WIDTH     = rdoq_pkg::QBITS_WIDTH,
    parameter int SCALE_WIDTH     = rdoq_pkg::SCALE_WIDTH,
    parameter int OUT_WIDTH       = rdoq_pkg::OUT_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       data_valid_in,
    input  logic [LEVEL_WIDTH-1:0]     l_level_double,
    input  logic [ABS_LEVEL_WIDTH-1:0] ui_abs_level,
    input  logic [QBITS_WIDTH-1:0]     i_q_bits,
    input  logic [SCALE_WIDTH-1:0]     error_scale,
    output logic                       data_valid_out,
    output logic [OUT_WIDTH-1:0]       distortion_out
);

    localparam int DW = LEVEL_WIDTH + 1;
    localparam int QW = 2 * DW;

    // Stage 1: reconstructed level, original level, scale.
    logic [LEVEL_WIDTH-1:0] recon_c;
    logic                   s1_valid;
    logic [LEVEL_WIDTH-1:0] s1_recon;
    logic [LEVEL_WIDTH-1:0] s1_level;
    logic [SCALE_WIDTH-1:0] s1_scale;

    // Stage 2: squared error and scale.
    logic signed [DW-1:0]   diff_c;
    logic signed [QW-1:0]   sq_c;
    logic                   s2_valid;
    logic [QW-1:0]          s2_sq;
    logic [SCALE_WIDTH-1:0] s2_scale;

    // Stage 3: weighted distortion.
    logic [OUT_WIDTH-1:0]   dist_c;
    logic                   s3_valid;
    logic [OUT_WIDTH-1:0]   s3_dist;

    rdoq_recon_clamp #(
        .LW (LEVEL_WIDTH),
        .AW (ABS_LEVEL_WIDTH),
        .QW (QBITS_WIDTH)
    ) u_recon_clamp (
        .ui_abs_level (ui_abs_level),
        .i_q_bits     (i_q_bits),
        .recon        (recon_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_recon <= '0;
            s1_level <= '0;
            s1_scale <= '0;
        end else begin
            s1_valid <= data_valid_in;
            if (data_valid_in) begin
                s1_recon <= recon_c;
                s1_level <= l_level_double;
                s1_scale <= error_scale;
            end
        end
    end

    // Sign-extend before squaring so the product of a negative diff stays exact.
    assign diff_c = $signed({1'b0, s1_level}) - $signed({1'b0, s1_recon});
    assign sq_c   = QW'(diff_c) * QW'(diff_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sq    <= '0;
            s2_scale <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sq    <= $unsigned(sq_c);
                s2_scale <= s1_scale;
            end
        end
    end

    assign dist_c = OUT_WIDTH'(s2_sq) * OUT_WIDTH'(s2_scale);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid <= 1'b0;
            s3_dist  <= '0;
        end else begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_dist <= dist_c;
            end
        end
    end

    assign data_valid_out = s3_valid;
    assign distortion_out = s3_dist;

endmodule

// File: tb/tb_rdoq_dist_cal.sv
// Self-checking bench for rdoq_dist_cal: directed corner vectors, gapped random stream,
// mid-stream reset, with an expected-result queue popped on data_valid_out.
module tb_rdoq_dist_cal;

    localparam int LW = 64;
    localparam int AW = 32;
    localparam int QW = 6;
    localparam int SW = 32;
    localparam int OW = 162;

    logic          clk;
    logic          rst_n;
    logic          data_valid_in;
    logic [LW-1:0] l_level_double;
    logic [AW-1:0] ui_abs_level;
    logic [QW-1:0] i_q_bits;
    logic [SW-1:0] error_scale;
    logic          data_valid_out;
    logic [OW-1:0] distortion_out;

    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] last_exp;
    logic [2:0]    vexp;
    int            n_checks;
    int            n_fail;

    rdoq_dist_cal dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_valid_in  (data_valid_in),
        .l_level_double (l_level_double),
        .ui_abs_level   (ui_abs_level),
        .i_q_bits       (i_q_bits),
        .error_scale    (error_scale),
        .data_valid_out (data_valid_out),
        .distortion_out (distortion_out)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: absolute difference squared, computed unsigned.
    function automatic logic [OW-1:0] model(input logic [LW-1:0] level, input logic [AW-1:0] abs_l,
                                            input logic [QW-1:0] q, input logic [SW-1:0] scale);
        logic [LW+AW-1:0] sh;
        logic [LW-1:0]    rec;
        logic [LW-1:0]    ad;
        sh  = (LW+AW)'(abs_l) << q;
        rec = (sh[LW+AW-1:LW] != '0) ? {LW{1'b1}} : sh[LW-1:0];
        ad  = (level >= rec) ? level - rec : rec - level;
        return OW'(ad) * OW'(ad) * OW'(scale);
    endfunction

    // Drivers: inputs change 1 time unit after the rising edge.
    task automatic send(input logic [LW-1:0] level, input logic [AW-1:0] abs_l,
                        input logic [QW-1:0] q, input logic [SW-1:0] scale,
                        input logic [OW-1:0] expv);
        data_valid_in  = 1'b1;
        l_level_double = level;
        ui_abs_level   = abs_l;
        i_q_bits       = q;
        error_scale    = scale;
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            data_valid_in  = 1'b0;
            l_level_double = {$urandom, $urandom};
            ui_abs_level   = $urandom;
            i_q_bits       = QW'($urandom_range(0, 63));
            error_scale    = $urandom;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset(input int n);
        rst_n         = 1'b0;
        data_valid_in = 1'b0;
        exp_q.delete();
        last_exp      = '0;
        repeat (n) @(posedge clk);
        #1;
        check("reset_valid", OW'(data_valid_out), '0);
        check("reset_dist", distortion_out, '0);
        rst_n = 1'b1;
    endtask

    // Expected valid chain
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) vexp <= '0;
        else        vexp <= {vexp[1:0], data_valid_in};
    end

    // Scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            check("valid_out", OW'(data_valid_out), OW'(vexp[2]));
            if (data_valid_out) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", OW'(1), OW'(0));
                end else begin
                    last_exp = exp_q.pop_front();
                    check("dist", distortion_out, last_exp);
                end
            end else begin
                check("hold", distortion_out, last_exp);
            end
        end
    end

    initial begin
        logic [OW-1:0] m64;
        logic [LW-1:0] lv;
        logic [AW-1:0] ab;
        logic [QW-1:0] qb;
        logic [SW-1:0] sc;
        int            wait_cnt;

        n_checks       = 0;
        n_fail         = 0;
        last_exp       = '0;
        data_valid_in  = 1'b0;
        l_level_double = '0;
        ui_abs_level   = '0;
        i_q_bits       = '0;
        error_scale    = '0;
        rst_n          = 1'b0;
        #2;
        apply_reset(3);
        idle(2);

        // Directed vectors, first two back-to-back.
        m64 = (OW'(1) << 64) - OW'(1);
        send(64'd1000, 32'd2, 6'd8, 32'd10, OW'(2381440));
        send(64'd400,  32'd2, 6'd8, 32'd1,  OW'(12544));
        send(64'd1000, 32'd1, 6'd63, 32'd1,
             (OW'(1) << 126) - (OW'(1000) << 64) + OW'(1000000));
        send(64'd0, 32'd4, 6'd62, 32'd1, (OW'(1) << 128) - (OW'(1) << 65) + OW'(1));
        send(64'd0, 32'hFFFF_FFFF, 6'd63, 32'hFFFF_FFFF, m64 * m64 * OW'(32'hFFFF_FFFF));
        idle(1);
        // q=0 passes abs through; abs=0 reconstructs zero at any shift.
        send(64'd100, 32'd7, 6'd0, 32'd3, OW'(93 * 93 * 3));
        send(64'd9, 32'd0, 6'd40, 32'd2, OW'(162));
        send({LW{1'b1}}, 32'd0, 6'd0, 32'd1, m64 * m64);
        send(64'd5, 32'd5, 6'd0, 32'hFFFF_FFFF, '0);
        idle(4);

        // Gapped random stream.
        for (int i = 0; i < 40; i++) begin
            lv = {$urandom, $urandom};
            ab = (i % 3 == 0) ? AW'($urandom_range(0, 255)) : AW'($urandom);
            qb = QW'($urandom_range(0, 63));
            sc = $urandom;
            send(lv, ab, qb, sc, model(lv, ab, qb, sc));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(5);

        // Reset with two samples in flight: they must never appear.
        send(64'd1234, 32'd3, 6'd4, 32'd9, model(64'd1234, 32'd3, 6'd4, 32'd9));
        send(64'd77, 32'd1, 6'd1, 32'd5, model(64'd77, 32'd1, 6'd1, 32'd5));
        apply_reset(2);
        idle(5);
        send(64'd50, 32'd3, 6'd2, 32'd4, OW'(38 * 38 * 4));
        idle(1);
        send(64'd10, 32'd1, 6'd5, 32'd1, OW'(22 * 22));

        // Drain with a bounded wait.
        idle(1);
        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 20) begin
            idle(1);
            wait_cnt++;
        end
        idle(2);
        check("drain_left", OW'(exp_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
